trace_fifo: RTL and testbench
=============================

// Module: trace_fifo
//
// PURPOSE
//   TR end of the TR/CSL trace interface: a show-ahead FIFO that captures one
//   PC/IR record per executed instruction.
//   The console drains the FIFO through trADV, clears it with trCLR, and reads
//   status (trITR) and head record (trPCIR).
//   Sits beside the CPU; all inputs and outputs are on the single CPU clock.
//
// PARAMETERS
//   DEPTH_LOG2   9    log2 of entries (512); legal range 2..15
//
// PORTS
//   clk        in   1    clock (single clock domain)
//   rst        in   1    reset, asynchronous, active-high
//   trCLR      in   1    clear buffer, 1-cycle pulse from console
//   trADV      in   1    pop head record, 1-cycle pulse from console
//   cpuTRACE   in   1    capture strobe, 1 cycle per executed instruction
//   cpuPC      in   18   PC of the executed instruction
//   cpuIR      in   36   instruction register of the executed instruction
//   trITR      out  64   status: [0] EMPTY, [1] FULL, [2] OVF (sticky),
//                        [3:15]=0, [16:31] entry count (zero-ext), [32:63]=0
//   trPCIR     out  64   head record: [0:9] TS, [10:27] PC, [28:63] IR
//
// BEHAVIOUR
//   - Reset (async, active-high) and trCLR (sync) both force:
//     - count=0, rd/wr pointers=0, OVF=0
//     - trPCIR=0, trITR=0 except EMPTY=1
//     - timestamp counter=0
//   - trCLR has top priority; a push or pop in the same cycle is discarded.
//   - Push (cpuTRACE=1):
//     - Writes {TS, cpuPC, cpuIR} at wr pointer.
//     - If FULL and no pop in the same cycle: record dropped, OVF set.
//       OVF stays set until rst or trCLR.
//   - Pop (trADV=1 and not EMPTY):
//     - Advances rd pointer.
//     - trADV while EMPTY is ignored; no underflow and no state change.
//   - Simultaneous push+pop:
//     - Count unchanged.
//     - When FULL, the push is accepted (the popped slot is reused).
//     - When EMPTY, only the push takes effect.
//   - Pointers are DEPTH_LOG2 bits and wrap modulo 2**DEPTH_LOG2.
//   - Count is DEPTH_LOG2+1 bits. FULL = (count == 2**DEPTH_LOG2); EMPTY = (count == 0).
//   - Outputs are registered:
//     - trITR reflects the event one cycle after the push/pop/clear edge.
//     - trPCIR shows the head entry one cycle after the edge that makes it head:
//       first push into an empty FIFO, or a pop exposing the next entry.
//     - Push into empty then pop on the next cycle is legal. trPCIR returns
//       to 0 when the FIFO is EMPTY.
//   - Storage: inferred block RAM with a one-entry prefetch register so the
//     head is always presented (show-ahead). RAM read-during-write to the
//     same address must not corrupt trPCIR; bypass the write data to the head.
//
// CONFIGURATION
//   TRACE_TIMESTAMP_EN
//     defined:
//       - 10-bit counter increments every clk and saturates at 1023.
//       - On each accepted push its value is stored in TS [0:9], and it
//         restarts at 1 on that same edge.
//       - Counter resets to 0 on rst or trCLR.
//     undefined: TS field is constant 0; no counter logic is generated.
//
// TESTING
//   1 Reset -> trITR=64'h8000_0000_0000_0000 (EMPTY), trPCIR=0; trADV ignored.
//   2 Push PC=18'o001000 IR=36'o254000001000, then pop ->
//       - cycle+1: count=1, EMPTY=0, trPCIR PC/IR match
//       - after trADV: EMPTY=1, trPCIR=0
//   3 DEPTH_LOG2=2: 5 pushes PC=1..5 ->
//       - FULL=1, count=4, OVF=1
//       - pops return PC 1,2,3,4, then EMPTY
//   4 FULL, simultaneous cpuTRACE(PC=6)+trADV ->
//       - count stays 4, OVF unchanged
//       - subsequent pops yield PC 2,3,4,6
//   5 trCLR coincident with cpuTRACE and trADV at count=3 ->
//       - count=0, EMPTY=1, OVF=0, push discarded
//   6 TRACE_TIMESTAMP_EN: pushes 7 cycles apart, then 2000 cycles ->
//       - TS=7 on the 2nd record, TS=1023 (saturated) on the 3rd
//       - macro undefined: TS=0 on all records

Source files
------------

// File: rtl/trace_fifo.sv
// Show-ahead trace FIFO capturing one {TS, PC, IR} record per executed instruction.
// The optional timestamp counter is enabled by defining TRACE_TIMESTAMP_EN.
module trace_fifo #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trCLR,
    input  logic        trADV,
    input  logic        cpuTRACE,
    input  logic [17:0] cpuPC,
    input  logic [35:0] cpuIR,
    output logic [63:0] trITR,
    output logic [63:0] trPCIR
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    logic [63:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  empty, full, pop, push, drop;
    logic [9:0]            ts;
    logic [63:0]           rdata_q;
    logic                  head_vld_q;
    logic [63:0]           itr_q;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_W'(DEPTH));
        pop      = trADV && !empty && !trCLR;
        push     = cpuTRACE && !trCLR && (!full || pop);
        drop     = cpuTRACE && !trCLR && full && !pop;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (trCLR) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (drop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [9:0] ts_q, ts_d;

    // Saturating cycle counter; an accepted push captures it and restarts it at 1.
    always_comb begin
        ts_d = ts_q;
        if (trCLR)                ts_d = '0;
        else if (push)            ts_d = 10'd1;
        else if (ts_q != 10'd1023) ts_d = ts_q + 10'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts_q <= '0;
        else     ts_q <= ts_d;
    end

    assign ts = ts_q;
`else
    assign ts = '0;
`endif

    // Read-first RAM: when a full push+pop overwrites the head slot, the old head
    // is exactly what the lagging output stage must present, so no bypass is needed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {ts, cpuPC, cpuIR};
        rdata_q <= mem[rd_ptr_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            itr_q      <= {1'b1, 63'b0};
            head_vld_q <= 1'b0;
        end else if (trCLR) begin
            itr_q      <= {1'b1, 63'b0};
            head_vld_q <= 1'b0;
        end else begin
            itr_q      <= {empty, full, ovf_q, 13'b0, 16'(count_q), 32'b0};
            head_vld_q <= !empty;
        end
    end

    assign trITR  = itr_q;
    assign trPCIR = head_vld_q ? rdata_q : 64'b0;

endmodule

// File: tb/tb_trace_fifo.sv
// Self-checking bench for trace_fifo (DEPTH_LOG2=2): directed tables plus random
// traffic compared against a queue-based reference model.
module tb_trace_fifo;
    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;
    localparam logic [63:0] EMPTY_ITR = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst, trCLR, trADV, cpuTRACE;
    logic [17:0] cpuPC;
    logic [35:0] cpuIR;
    logic [63:0] trITR, trPCIR;

    int n_chk  = 0;
    int n_pass = 0;

    logic [63:0] mq[$];
    bit          movf;
    int          mts;

    trace_fifo #(.DEPTH_LOG2(DL2)) dut (
        .clk(clk), .rst(rst), .trCLR(trCLR), .trADV(trADV), .cpuTRACE(cpuTRACE),
        .cpuPC(cpuPC), .cpuIR(cpuIR), .trITR(trITR), .trPCIR(trPCIR)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tr, adv, clr;
        logic [17:0] pc;
        bit          e_empty, e_full, e_ovf;
        int          e_cnt;
        logic [17:0] e_pc;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h want=%h", name, got, exp);
    endtask

    function automatic logic [63:0] model_itr();
        return {mq.size() == 0, mq.size() == DEPTH, movf, 13'b0, 16'(mq.size()), 32'b0};
    endfunction

    function automatic logic [63:0] model_pcir();
        return (mq.size() != 0) ? mq[0] : 64'b0;
    endfunction

    task automatic model_update(input logic tr, adv, clr, input logic [17:0] pc,
                                input logic [35:0] ir);
        bit full, popok, pushok;
        logic [9:0] tsf;
        if (clr) begin
            mq.delete();
            movf = 0;
            mts  = 0;
            return;
        end
        full   = (mq.size() == DEPTH);
        popok  = adv && (mq.size() > 0);
        pushok = tr && (!full || popok);
        if (tr && !pushok) movf = 1;
`ifdef TRACE_TIMESTAMP_EN
        tsf = 10'(mts);
`else
        tsf = 10'd0;
`endif
        if (popok) void'(mq.pop_front());
        if (pushok) mq.push_back({tsf, pc, ir});
        if (pushok) mts = 1;
        else if (mts < 1023) mts++;
    endtask

    // One clock: outputs after the edge reflect the model state before it (or clear).
    task automatic step(input logic tr, adv, clr, input logic [17:0] pc, input logic [35:0] ir);
        logic [63:0] e_itr, e_pcir;
        e_itr  = clr ? EMPTY_ITR : model_itr();
        e_pcir = clr ? 64'b0 : model_pcir();
        cpuTRACE = tr; trADV = adv; trCLR = clr; cpuPC = pc; cpuIR = ir;
        @(posedge clk);
        #1;
        model_update(tr, adv, clr, pc, ir);
        cpuTRACE = 1'b0; trADV = 1'b0; trCLR = 1'b0;
        check("model_itr", trITR, e_itr);
        check("model_pcir", trPCIR, e_pcir);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 18'd0, 36'd0);
    endtask

    initial begin
        vec_t        tbl[$];
        logic [17:0] pc2;
        logic [35:0] ir2;
        logic [53:0] rec2;

        rst = 1'b1; trCLR = 1'b0; trADV = 1'b0; cpuTRACE = 1'b0; cpuPC = '0; cpuIR = '0;
        mq.delete(); movf = 0; mts = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset_itr", trITR, EMPTY_ITR);
        check("reset_pcir", trPCIR, 64'b0);

        step(1'b0, 1'b1, 1'b0, 18'd0, 36'd0);
        idle();
        check("adv_empty_itr", trITR, EMPTY_ITR);
        check("adv_empty_pcir", trPCIR, 64'b0);

        pc2 = 18'o001000;
        ir2 = 36'o254000001000;
        rec2 = {pc2, ir2};
        step(1'b1, 1'b0, 1'b0, pc2, ir2);
        idle();
        check("single_cnt", trITR[47:32], 64'd1);
        check("single_empty", trITR[63], 64'd0);
        check("single_rec", trPCIR[53:0], rec2);
        step(1'b0, 1'b1, 1'b0, 18'd0, 36'd0);
        idle();
        check("single_pop_empty", trITR[63], 64'd1);
        check("single_pop_pcir", trPCIR, 64'b0);

        //            tr    adv   clr   pc     emp full ovf cnt head
        tbl.push_back('{1'b1, 1'b0, 1'b0, 18'd1,  0, 0, 0, 1, 18'd1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 18'd2,  0, 0, 0, 2, 18'd1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 18'd3,  0, 0, 0, 3, 18'd1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 18'd4,  0, 1, 0, 4, 18'd1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 18'd5,  0, 1, 1, 4, 18'd1});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 18'd6,  0, 1, 1, 4, 18'd2});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 18'd0,  0, 0, 1, 3, 18'd3});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 18'd0,  0, 0, 1, 2, 18'd4});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 18'd0,  0, 0, 1, 1, 18'd6});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 18'd0,  1, 0, 1, 0, 18'd0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 18'd0,  1, 0, 1, 0, 18'd0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 18'd7,  0, 0, 1, 1, 18'd7});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 18'd8,  0, 0, 1, 2, 18'd7});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 18'd9,  0, 0, 1, 3, 18'd7});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 18'd11, 1, 0, 0, 0, 18'd0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 18'd10, 0, 0, 0, 1, 18'd10});

        foreach (tbl[i]) begin
            step(tbl[i].tr, tbl[i].adv, tbl[i].clr, tbl[i].pc, {18'd0, tbl[i].pc});
            idle();
            check($sformatf("tbl%0d_empty", i), trITR[63], tbl[i].e_empty);
            check($sformatf("tbl%0d_full", i),  trITR[62], tbl[i].e_full);
            check($sformatf("tbl%0d_ovf", i),   trITR[61], tbl[i].e_ovf);
            check($sformatf("tbl%0d_cnt", i),   trITR[47:32], 64'(tbl[i].e_cnt));
            check($sformatf("tbl%0d_pc", i),    trPCIR[53:36], tbl[i].e_pc);
        end

        step(1'b0, 1'b0, 1'b1, 18'd0, 36'd0);
        step(1'b1, 1'b0, 1'b0, 18'd21, 36'd21);
        repeat (6) idle();
        step(1'b1, 1'b0, 1'b0, 18'd22, 36'd22);
        repeat (2000) idle();
        step(1'b1, 1'b0, 1'b0, 18'd23, 36'd23);
        idle();
        check("ts_rec1", trPCIR[63:54], 64'd0);
        step(1'b0, 1'b1, 1'b0, 18'd0, 36'd0);
        idle();
        check("ts_rec2_pc", trPCIR[53:36], 64'd22);
`ifdef TRACE_TIMESTAMP_EN
        check("ts_rec2", trPCIR[63:54], 64'd7);
`else
        check("ts_rec2", trPCIR[63:54], 64'd0);
`endif
        step(1'b0, 1'b1, 1'b0, 18'd0, 36'd0);
        idle();
        check("ts_rec3_pc", trPCIR[53:36], 64'd23);
`ifdef TRACE_TIMESTAMP_EN
        check("ts_rec3", trPCIR[63:54], 64'd1023);
`else
        check("ts_rec3", trPCIR[63:54], 64'd0);
`endif

        for (int k = 0; k < 3000; k++) begin
            logic tr, adv, clr;
            tr  = ($urandom_range(0, 99) < 55);
            adv = ($urandom_range(0, 99) < 45);
            clr = ($urandom_range(0, 99) < 2);
            step(tr, adv, clr, 18'($urandom()), 36'({$urandom(), $urandom()}));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
